// File: rtl/iter_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and default geometry.
package iter_mdu_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_MULT  = 4'b0001,
        OP_MULTU = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_DIVU  = 4'b0100,
        OP_MTHI  = 4'b0101,
        OP_MTLO  = 4'b0110
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/iter_mdu_if.sv
// Request/result bundle between a pipeline (master) and the MDU (slave).
interface iter_mdu_if #(
    parameter int WIDTH = iter_mdu_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic             flush;
    logic [3:0]       MDUop;
    logic [WIDTH-1:0] MDU_opA;
    logic [WIDTH-1:0] MDU_opB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, flush, MDUop, MDU_opA, MDU_opB,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, flush, MDUop, MDU_opA, MDU_opB,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/iter_mdu_signfix.sv
// Combinational sign handling: operand magnitudes on the way in, sign
// correction plus divide-by-zero / signed-overflow results on the way out.
module iter_mdu_signfix
    import iter_mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [3:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             a_neg,
    output logic             b_neg,
    input  logic [3:0]       op_q,
    input  logic [WIDTH-1:0] a_q,
    input  logic [WIDTH-1:0] b_q,
    input  logic             a_neg_q,
    input  logic             b_neg_q,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic               res_neg;
    logic [2*WIDTH-1:0] prod_neg;

    assign a_neg = op_is_signed(op_in) & a_in[WIDTH-1];
    assign b_neg = op_is_signed(op_in) & b_in[WIDTH-1];
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign a_mag = a_neg ? -a_in : a_in;
    assign b_mag = b_neg ? -b_in : b_in;

    assign res_neg  = a_neg_q ^ b_neg_q;
    assign prod_neg = -{raw_hi, raw_lo};

    // NOTE: every output gets a default first so no path through this block can infer a latch.
    always_comb begin
        hi_out = raw_hi;
        lo_out = raw_lo;
        if (op_is_div(op_q)) begin
            if (b_q == '0) begin
                hi_out = a_q;
                lo_out = '1;
            end else if ((op_q == OP_DIV) && (a_q == MOST_NEG) && (b_q == '1)) begin
                hi_out = '0;
                lo_out = MOST_NEG;
            end else begin
                lo_out = res_neg ? -raw_lo : raw_lo;
                hi_out = a_neg_q ? -raw_hi : raw_hi;
            end
        end else if (res_neg) begin
            {hi_out, lo_out} = prod_neg;
        end
    end

endmodule

// File: rtl/iter_mdu.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Latency is WIDTH CALC steps plus one FIX cycle.
module iter_mdu
    import iter_mdu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input logic     clk,
    input logic     reset,
    iter_mdu_if.slave bus
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    iter_mdu_signfix #(.WIDTH(WIDTH)) u_signfix (
        .op_in   (bus.MDUop),
        .a_in    (bus.MDU_opA),
        .b_in    (bus.MDU_opB),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .a_neg   (a_neg),
        .b_neg   (b_neg),
        .op_q    (op_q),
        .a_q     (a_q),
        .b_q     (b_q),
        .a_neg_q (a_neg_q),
        .b_neg_q (b_neg_q),
        .raw_hi  (acc_hi),
        .raw_lo  (acc_lo),
        .hi_out  (fix_hi),
        .lo_out  (fix_lo)
    );

    // Multiply: acc_lo holds the multiplier and shifts out as the product's low half fills in.
    // Divide:   acc_hi is the partial remainder, acc_lo shifts the dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (op_is_div(op_q)) begin
            nxt_hi = div_ok ? div_diff : div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ok};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (op_is_arith(bus.MDUop)) begin
                                op_q    <= bus.MDUop;
                                a_q     <= bus.MDU_opA;
                                b_q     <= bus.MDU_opB;
                                a_neg_q <= a_neg;
                                b_neg_q <= b_neg;
                                acc_hi  <= '0;
                                acc_lo  <= op_is_div(bus.MDUop) ? a_mag : b_mag;
                                opnd    <= op_is_div(bus.MDUop) ? b_mag : a_mag;
                                cnt     <= CNT_W'(WIDTH);
                                busy_q  <= 1'b1;
                                state   <= ST_CALC;
                            end else if (bus.MDUop == OP_MTHI) begin
                                hi_q <= bus.MDU_opA;
                            end else if (bus.MDUop == OP_MTLO) begin
                                lo_q <= bus.MDU_opA;
                            end
                        end
                    end
                    ST_CALC: begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_iter_mdu.sv
// Directed bench for iter_mdu at WIDTH=32: a vector table of arithmetic ops
// plus hand-written flush, reset, mthi/mtlo and nop sequences.
module tb_iter_mdu;
    import iter_mdu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;
    vec_t vecs[13];

    iter_mdu_if #(.WIDTH(W)) bus ();

    iter_mdu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one arithmetic op and watches 40 cycles. flush_at/mthi_at (0 = unused)
    // inject a flush or a mthi request at that cycle after acceptance.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int flush_at, input int mthi_at,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input string name);
        int busy_n;
        int done_n;
        int done_at;
        logic [W-1:0] held_hi;
        logic [W-1:0] held_lo;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        held_hi = '0;
        held_lo = '0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.MDUop   = op;
        bus.MDU_opA = a;
        bus.MDU_opB = b;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
            if (i == W + 1) begin
                held_hi = bus.HI;
                held_lo = bus.LO;
            end
            bus.flush = (i == flush_at);
            if (i == mthi_at) begin
                bus.start   = 1'b1;
                bus.MDUop   = OP_MTHI;
                bus.MDU_opA = 32'h1234_5678;
            end else begin
                bus.start = 1'b0;
            end
            if (i < 40) @(negedge clk);
        end
        bus.flush = 1'b0;
        check({name, " busy_cycles"}, 64'(busy_n), 64'(flush_at != 0 ? flush_at : W + 1));
        check({name, " done_pulses"}, 64'(done_n), 64'(flush_at != 0 ? 0 : 1));
        check({name, " done_cycle"}, 64'(done_at), 64'(flush_at != 0 ? 0 : W + 2));
        check({name, " held_hilo"}, {held_hi, held_lo}, {model_hi, model_lo});
        check({name, " hilo"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    task automatic write_reg(input logic [3:0] op, input logic [W-1:0] val, input string name);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.MDUop   = op;
        bus.MDU_opA = val;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (op == OP_MTHI) model_hi = val;
        else model_lo = val;
        check({name, " hilo"}, {bus.HI, bus.LO}, {model_hi, model_lo});
        check({name, " busy_done"}, {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_hi = '0;
        model_lo = '0;
        reset = 1'b0;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.MDUop   = OP_NOP;
        bus.MDU_opA = '0;
        bus.MDU_opB = '0;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5"};
        vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, "multu_maxx2"};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
        vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow"};
        vecs[4]  = '{OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, "divu_by0"};
        vecs[5]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0"};
        vecs[6]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100by7"};
        vecs[7]  = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, "mult_maxpos"};
        vecs[8]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_maxsq"};
        vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"};
        vecs[10] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2"};
        vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, "divu_maxby16"};
        vecs[12] = '{OP_MULT,  32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, "mult_zero"};

        #1;
        check("reset_state", {bus.HI, bus.LO}, 64'd0);
        check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, vecs[i].hi, vecs[i].lo, vecs[i].name);
        end

        // mthi while busy is dropped; the product lands in HI/LO instead.
        run_op(OP_MULT, 32'h0000_0003, 32'h0000_0004, 0, 5, 32'h0000_0000, 32'h0000_000C, "mthi_busy");
        write_reg(OP_MTHI, 32'h1234_5678, "mthi_idle");
        write_reg(OP_MTLO, 32'hABCD_0000, "mtlo_idle");

        // nop codes, and flush coincident with start in IDLE, leave everything untouched.
        @(negedge clk);
        bus.start = 1'b1;
        bus.MDUop = OP_NOP;
        @(negedge clk);
        bus.MDUop = 4'b1111;
        @(negedge clk);
        bus.flush   = 1'b1;
        bus.MDUop   = OP_MTHI;
        bus.MDU_opA = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.MDUop = OP_MULT;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("nop_flush_hilo", {bus.HI, bus.LO}, {model_hi, model_lo});
        check("nop_flush_busy", {63'd0, bus.busy}, 64'd0);

        run_op(OP_DIV, 32'h0000_0064, 32'h0000_0007, 10, 0, 32'h1234_5678, 32'hABCD_0000, "flush_calc");
        run_op(OP_MULT, 32'h0000_0003, 32'h0000_0004, W + 1, 0, 32'h1234_5678, 32'hABCD_0000, "flush_fix");

        // Reset mid-multiply clears immediately; the first edge after release accepts a start.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.MDUop   = OP_MULT;
        bus.MDU_opA = 32'h0000_0003;
        bus.MDU_opB = 32'h0000_0004;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mid_hilo", {bus.HI, bus.LO}, 64'd0);
        check("reset_mid_busy", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        check("reset_mid_nodone", {63'd0, bus.done}, 64'd0);
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.MDU_opB = 32'h0000_0005;
        @(negedge clk);
        bus.start = 1'b0;
        check("post_reset_accept", {63'd0, bus.busy}, 64'd1);
        repeat (W + 1) @(negedge clk);
        check("post_reset_done", {63'd0, bus.done}, 64'd1);
        check("post_reset_hilo", {bus.HI, bus.LO}, {32'h0000_0000, 32'h0000_000F});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iter_mdu.md
ITER_MDU -- requirements
Module: iter_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal values are even and 8..64.
REQ-002 Parameter CNT_W, default 6, iteration-counter width; must satisfy 2**CNT_W > WIDTH.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  requests the operation on MDUop for this cycle.
REQ-006 flush  input  1  aborts any operation in flight.
REQ-007 MDUop  input  4  0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, others nop.
REQ-008 MDU_opA  input  WIDTH  multiplicand, dividend, or mthi/mtlo data.
REQ-009 MDU_opB  input  WIDTH  multiplier or divisor.
REQ-010 busy  output  1  high while an arithmetic operation is in flight.
REQ-011 done  output  1  one-cycle pulse when HI/LO commit an arithmetic result.
REQ-012 HI  output  WIDTH  architectural HI register.
REQ-013 LO  output  WIDTH  architectural LO register.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIX.
REQ-015 In IDLE, start with an op of 0001-0100 SHALL latch the operands, the op and the sign flags, set the counter to WIDTH, and enter CALC; busy is 1 from the next cycle.
REQ-016 In IDLE, start with mthi or mtlo SHALL write MDU_opA into HI or LO at that edge; busy stays 0 and done stays 0.
REQ-017 Start with a nop op SHALL have no effect.
REQ-018 Start, including mthi and mtlo, SHALL be ignored while busy=1; the caller must stall.
REQ-019 CALC SHALL perform one radix-2 step per cycle for exactly WIDTH cycles.
- Multiply: shift-add on operand magnitudes.
- Divide: restoring division on operand magnitudes.
REQ-020 When the counter reaches 0, the FSM SHALL enter FIX.
REQ-021 FIX SHALL apply sign correction, commit HI/LO, pulse done and return to IDLE, all in one cycle.
REQ-022 For a start accepted at edge 0, HI/LO SHALL update at edge WIDTH+1, busy SHALL be high for exactly WIDTH+1 cycles, and done SHALL be high in the cycle following edge WIDTH+1.
REQ-023 HI/LO SHALL remain unchanged during CALC, so old values stay readable.
REQ-024 Multiply: {HI,LO} = the full 2*WIDTH-bit product; signed for mult, unsigned for multu.
REQ-025 Division: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
REQ-026 Divide by zero, signed or unsigned: LO = all ones, HI = MDU_opA, using the same latency.
REQ-027 Signed overflow, most-negative divided by -1: LO = most-negative, HI = 0.
REQ-028 flush=1 SHALL return the FSM to IDLE at the next edge with HI/LO unchanged and no done pulse.
REQ-029 flush SHALL take priority over start when both are high in the same cycle.
REQ-030 flush in IDLE SHALL be harmless and SHALL discard a coincident start.
REQ-031 flush in FIX SHALL suppress both the commit and the done pulse.

Reset
REQ-032 Asserting reset low SHALL immediately force IDLE, busy=0, done=0, HI=0, LO=0, counter=0 and all internal registers to 0, including mid-operation.
REQ-033 The first accepted start SHALL be the first edge after reset deasserts.

Structure
REQ-034 A shared package SHALL hold the MDUop codes, the state encoding and the default WIDTH.
REQ-035 One sub-module, iter_mdu_signfix, SHALL be combinational: magnitude extraction and result sign correction, including the zero and overflow cases.
REQ-036 The FSM, counter and shift registers SHALL remain in iter_mdu.

Verification (WIDTH=32)
REQ-037 mult, A=FFFFFFFD, B=00000005 -> after 33 busy cycles, HI=FFFFFFFF, LO=FFFFFFF1, single done pulse.
REQ-038 multu, A=FFFFFFFF, B=00000002 -> HI=00000001, LO=FFFFFFFE.
REQ-039 div, A=FFFFFFF9, B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; then div, A=80000000, B=FFFFFFFF -> LO=80000000, HI=00000000.
REQ-040 divu, A=00000007, B=0 -> LO=FFFFFFFF, HI=00000007 after 33 busy cycles.
REQ-041 mthi 12345678 issued while busy -> ignored; HI takes the arithmetic result; mthi after done -> HI=12345678 next edge, busy stays 0.
REQ-042 Flush on cycle 10 of a div, and reset asserted mid-mult -> idle next edge (flush) or immediately (reset); HI/LO hold prior values (flush) or 0 (reset); no done.
